// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg -- shared fetch-stage definitions.
//   Reset PC, flush-cause encodings, fetch exception codes, FSM state
//   encoding and the output-buffer entry layout used by pc_fetch_ctrl and
//   fetch_out_buf.
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // flush_cause encodings
  localparam logic Exception              = 1'b0;
  localparam logic FailedBranchPrediction = 1'b1;

  // fetch exception codes
  localparam logic [4:0] EXCEPTION_NONE = 5'h00;
  localparam logic [4:0] EXCEPTION_ADEL = 5'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // nothing outstanding
    WAIT   = 2'd1,  // request accepted, data pending
    CANCEL = 2'd2   // redirected while outstanding, next data_ok is dropped
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  exc;
  } fetch_entry_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;  // wraps modulo 2^32
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf -- one-entry buffer between fetch and decode.
//   clk, rst   : clock, async active-low reset
//   flush      : drop the held entry (highest priority)
//   drain      : decode consumes the entry this cycle
//   push/entry : load a new entry (may coincide with drain)
//   valid/out  : held entry towards decode
module fetch_out_buf import pc_fetch_ctrl_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         drain,
  input  logic         push,
  input  fetch_entry_t push_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      entry <= push_entry;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- PC register, icache request FSM and fetch output buffer.
//   clk, rst                  : clock, async active-low reset
//   stall[0]                  : decode stall, holds the fetched instruction
//   flush/flush_cause         : redirect to epc_i (Exception) or
//                               branch_target_i (FailedBranchPrediction)
//   pred_taken_i/pred_target_i: predictor result for the current pc
//   inst_req/inst_addr        : icache request, one outstanding at most
//   inst_addr_ok/data_ok/rdata: icache handshake
//   if_valid/if_pc/if_inst/if_excepttype : instruction to decode
// Build option: FETCH_ADEL_CHECK_EN turns a misaligned pc into an AdEL
// entry instead of an icache request.
module pc_fetch_ctrl import pc_fetch_ctrl_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  stall,
  input  logic        flush,
  input  logic        flush_cause,
  input  logic [31:0] epc_i,
  input  logic [31:0] branch_target_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [4:0]  if_excepttype
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, req_pc;
  logic         buf_valid, can_fill, misaligned;
  logic         accept, data_push, adel_push;
  fetch_entry_t buf_entry, push_entry;
  logic [2:0]   stall_unused;

  assign stall_unused = stall[3:1];

  // Buffer can take a new entry if empty or being consumed this cycle.
  assign can_fill = !buf_valid || !stall[0];

`ifdef FETCH_ADEL_CHECK_EN
  assign misaligned = |pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    inst_req  = 1'b0;
    data_push = 1'b0;
    adel_push = 1'b0;
    unique case (state)
      IDLE: begin
        // rst gate keeps the request low while reset is held.
        if (rst && !flush && can_fill) begin
          if (misaligned) begin
            adel_push = 1'b1;
          end else begin
            inst_req = 1'b1;
            if (inst_addr_ok) state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // data_ok together with flush: the data is stale, nothing left to drop.
        if (inst_data_ok) begin
          state_nxt = IDLE;
          data_push = !flush;
        end else if (flush) begin
          state_nxt = CANCEL;
        end
      end
      CANCEL: begin
        if (inst_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = inst_req && inst_addr_ok;

  always_comb begin
    pc_nxt = pc;
    if (flush)
      pc_nxt = (flush_cause == Exception) ? epc_i : branch_target_i;
    else if (accept)
      pc_nxt = pred_taken_i ? pred_target_i : next_seq_pc(pc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (accept) req_pc <= pc;
    end
  end

  always_comb begin
    push_entry = '{pc: req_pc, inst: inst_rdata, exc: EXCEPTION_NONE};
    if (adel_push) push_entry = '{pc: pc, inst: 32'd0, exc: EXCEPTION_ADEL};
  end

  fetch_out_buf u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .drain      (!stall[0]),
    .push       (data_push || adel_push),
    .push_entry (push_entry),
    .valid      (buf_valid),
    .entry      (buf_entry)
  );

  assign inst_addr = pc;
  assign if_valid  = buf_valid;
  assign if_pc     = buf_entry.pc;
  assign if_inst   = buf_entry.inst;

`ifdef FETCH_ADEL_CHECK_EN
  assign if_excepttype = buf_entry.exc;
`else
  logic [4:0] exc_unused;
  assign exc_unused    = buf_entry.exc;
  assign if_excepttype = EXCEPTION_NONE;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, meaning first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-004 stall  in  4  pipeline stall vector; bit0 = decode stall, holds fetch output.
REQ-005 flush  in  1  pipeline flush request.
REQ-006 flush_cause  in  1  `Exception / `FailedBranchPrediction.
REQ-007 epc_i  in  32  exception/ERET redirect target.
REQ-008 branch_target_i  in  32  corrected PC on a failed branch prediction.
REQ-009 pred_taken_i / pred_target_i  in  1/32  branch predictor result for the current PC.
REQ-010 inst_req / inst_addr  out  1/32  icache request and word address.
REQ-011 inst_addr_ok / inst_data_ok / inst_rdata  in  1/1/32  icache accept, return, data.
REQ-012 if_valid / if_pc / if_inst  out  1/32/32  fetched instruction to decode.
REQ-013 if_excepttype  out  5  fetch exception code; `EXCEPTION_ADEL or zero.

Function
REQ-014 SHALL hold PC register pc; next PC: flush&`Exception -> epc_i; flush&`FailedBranchPrediction -> branch_target_i; else pred_taken_i ? pred_target_i : pc+4, wrapping modulo 2^32.
REQ-015 Flush SHALL take priority over stall[0] and over any pending request.
REQ-016 FSM states IDLE (nothing outstanding), WAIT (request accepted, data pending), CANCEL (redirected while outstanding; next data_ok discarded).
REQ-017 IDLE: inst_req=1 with inst_addr=pc whenever output buffer empty or being drained; inst_addr_ok -> WAIT, pc advances per REQ-014.
REQ-018 WAIT: inst_data_ok without flush -> instruction written to output buffer, state IDLE; flush before data_ok -> CANCEL.
REQ-019 CANCEL: inst_req=0; inst_data_ok -> data dropped, state IDLE.
REQ-020 flush and inst_data_ok in the same cycle in WAIT SHALL drop the data and go IDLE, not CANCEL.
REQ-021 At most one request SHALL be outstanding; inst_req never asserted in WAIT or CANCEL.
REQ-022 Output buffer SHALL be one entry; if_valid holds, with if_pc/if_inst stable, while stall[0]=1.
REQ-023 flush SHALL clear if_valid on the next edge.
REQ-024 Latency: inst_addr_ok at cycle N, data_ok at N+k -> if_valid at N+k+1.
REQ-025 inst_addr SHALL stay stable while inst_req=1 and inst_addr_ok=0, unless flush redirects it.

Reset
REQ-026 On rst low, asynchronously: pc=RESET_PC, state IDLE, if_valid=0, if_pc=0, if_inst=0, if_excepttype=0, inst_req=0.
REQ-027 First inst_req SHALL assert the first cycle after rst deasserts; a transaction pending at reset is abandoned with no CANCEL tracking.

Configuration
REQ-028 Macro FETCH_ADEL_CHECK_EN: when defined, pc[1:0]!=0 SHALL issue no request and push if_valid=1, if_inst=0, if_excepttype=`EXCEPTION_ADEL into the buffer.
REQ-029 Without FETCH_ADEL_CHECK_EN, if_excepttype SHALL be constant zero and misaligned pc is issued unchanged.

Structure
REQ-030 Reset PC value, FSM state encodings and the exception codes SHALL live in the shared defines package alongside `Exception/`FailedBranchPrediction.
REQ-031 The output buffer SHALL be a sub-module, fetch_out_buf.

Verification
REQ-032 Reset release, icache addr_ok and data_ok immediate -> inst_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on successive requests.
REQ-033 Exception flush with epc_i=0xBFC00380 while in WAIT -> CANCEL, old data_ok dropped, next inst_addr=0xBFC00380, if_valid=0 meanwhile.
REQ-034 Failed prediction flush with branch_target_i=0x80001000 coincident with data_ok -> data dropped, next request 0x80001000.
REQ-035 stall[0]=1 for 3 cycles with if_valid=1 -> if_pc/if_inst unchanged, no new inst_req beyond buffer capacity.
REQ-036 pred_taken_i=1, pred_target_i=0x80000010 at pc=0x80000000 -> next inst_addr 0x80000010; pc=0xFFFFFFFC not taken -> 0x00000000.
REQ-037 FETCH_ADEL_CHECK_EN defined, epc_i=0x80000002 -> no inst_req, if_excepttype=`EXCEPTION_ADEL, if_pc=0x80000002.
